mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_if.sv | 38 +++
 rtl/mem_arb.sv | 138 +++++++++++++
 tb/tb_mem_arb.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_if.sv
// Bus bundle for mem_arb: fetch port, data port and the shared memory port.
// slave  : seen from the arbiter (requests in, acks out, memory request out).
// master : seen from the surrounding requesters and memory model.
interface mem_arb_if #(
  parameter int XLEN = 32
);
  // Fetch port
  logic            i_req;
  logic [XLEN-1:0] i_addr;
  logic            i_ack;
  logic [XLEN-1:0] i_rdata;

  // Data (load/store) port
  logic            d_req;
  logic            d_we;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic            d_ack;
  logic [XLEN-1:0] d_rdata;

  // Memory port
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: two-requester (fetch / data) arbiter in front of a single-port
// memory with one transaction outstanding. Data has priority over fetch.
// Optional feature: define MEM_ARB_STARVE_EN to compile in a starvation guard
// that hands the memory to fetch after STARVE_MAX consecutive data grants
// made while fetch was waiting.
module mem_arb #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4    // legal range 1..15
) (
  input  logic      clk,
  input  logic      rst_n,
  mem_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t          state_q, state_d;

  logic            mem_req_q,   mem_req_d;
  logic            mem_we_q,    mem_we_d;
  logic [XLEN-1:0] mem_addr_q,  mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;

  logic            grant_i;
  logic            grant_d;
  logic            fetch_turn;   // starvation guard forces fetch this arbitration

`ifdef MEM_ARB_STARVE_EN
  logic [3:0] starve_q, starve_d;

  assign fetch_turn = (starve_q == 4'(STARVE_MAX));

  // Count data grants taken while fetch waits; any other grant clears it.
  always_comb begin
    starve_d = starve_q;
    if (grant_i) begin
      starve_d = 4'd0;
    end else if (grant_d) begin
      starve_d = bus.i_req ? (starve_q + 4'd1) : 4'd0;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign fetch_turn = 1'b0;
`endif

  // Arbitration: only in IDLE; data wins unless the guard gives fetch its turn.
  always_comb begin
    grant_d = (state_q == IDLE) && bus.d_req && !(fetch_turn && bus.i_req);
    grant_i = (state_q == IDLE) && bus.i_req && !grant_d;
  end

  // Next-state and next memory-port values.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
        end else if (grant_i) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.i_addr;
          mem_wdata_d = '0;
        end
      end

      BUSY_I, BUSY_D: begin
        // Memory port holds steady; completion forces one idle bubble.
        if (bus.mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and registered memory-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values, regardless of statement order.
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // Acks follow mem_ack in the same cycle; a mem_ack seen in IDLE is dropped.
  // Read data is zeroed whenever its ack is low.
  assign bus.i_ack   = (state_q == BUSY_I) && bus.mem_ack;
  assign bus.d_ack   = (state_q == BUSY_D) && bus.mem_ack;
  assign bus.i_rdata = bus.i_ack ? bus.mem_rdata : '0;
  assign bus.d_rdata = bus.d_ack ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_arb.sv
// Directed self-checking bench for mem_arb. The testbench plays both the
// requesters and the memory; inputs change 1 time unit after the rising edge.
// Starvation expectations follow MEM_ARB_STARVE_EN when it is defined.
module tb_mem_arb;

  localparam int XLEN = 32;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  mem_arb_if #(.XLEN(XLEN)) bus ();

  mem_arb #(.XLEN(XLEN), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the arbiter to raise mem_req.
  task automatic wait_busy(input string tag);
    int n = 0;
    while (!bus.mem_req && n < 20) begin
      tick();
      n++;
    end
    if (!bus.mem_req) check({tag, "_timeout"}, 0, 1);
  endtask

  // One-cycle memory completion; requester drops req on seeing its ack.
  task automatic respond(input logic [XLEN-1:0] rd, input bit keep_d,
                         output bit ia, output bit da,
                         output logic [XLEN-1:0] ir, output logic [XLEN-1:0] dr);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rd;
    #1;
    ia = bus.i_ack;
    da = bus.d_ack;
    ir = bus.i_rdata;
    dr = bus.d_rdata;
    if (ia) bus.i_req = 1'b0;
    if (da && !keep_d) bus.d_req = 1'b0;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  bit              ia, da;
  logic [XLEN-1:0] ir, dr;
  logic [7:0]      fetch_seq;
  logic [7:0]      exp_seq;

  initial begin
    rst_n         = 1'b0;
    bus.i_req     = 1'b0;
    bus.i_addr    = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;

    // Reset state
    #23;
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_i_ack", bus.i_ack, 0);
    check("rst_d_ack", bus.d_ack, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("idle_mem_req", bus.mem_req, 0);

    // Single fetch, memory answers two cycles after request issue
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h100;
    tick();
    check("f_mem_req", bus.mem_req, 1);
    check("f_mem_addr", bus.mem_addr, 32'h100);
    check("f_mem_we", bus.mem_we, 0);
    check("f_i_ack_wait", bus.i_ack, 0);
    tick();
    check("f_hold_req", bus.mem_req, 1);
    respond(32'h00A00093, 1'b0, ia, da, ir, dr);
    check("f_i_ack", ia, 1);
    check("f_d_ack", da, 0);
    check("f_i_rdata", ir, 32'h00A00093);
    check("f_d_rdata", dr, 0);
    check("f_bubble", bus.mem_req, 0);
    check("f_i_ack_end", bus.i_ack, 0);

    // Simultaneous store + fetch: data first, fetch after one idle cycle
    bus.i_req   = 1'b1;
    bus.i_addr  = 32'h104;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h200;
    bus.d_wdata = 32'hDEADBEEF;
    tick();
    check("s_mem_we", bus.mem_we, 1);
    check("s_mem_addr", bus.mem_addr, 32'h200);
    check("s_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    respond(32'h11, 1'b0, ia, da, ir, dr);
    check("s_d_ack", da, 1);
    check("s_i_ack", ia, 0);
    check("s_i_rdata", ir, 0);
    check("s_bubble", bus.mem_req, 0);
    bus.d_we = 1'b0;
    tick();
    check("s_f_req", bus.mem_req, 1);
    check("s_f_addr", bus.mem_addr, 32'h104);
    check("s_f_we", bus.mem_we, 0);
    check("s_f_wdata", bus.mem_wdata, 0);
    respond(32'h13, 1'b0, ia, da, ir, dr);
    check("s_f_i_ack", ia, 1);
    check("s_f_i_rdata", ir, 32'h13);

    // Load with a three-cycle memory
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h300;
    tick();
    check("l_mem_addr", bus.mem_addr, 32'h300);
    check("l_mem_we", bus.mem_we, 0);
    tick();
    tick();
    check("l_no_ack_yet", bus.d_ack, 0);
    respond(32'hCAFEF00D, 1'b0, ia, da, ir, dr);
    check("l_d_ack", da, 1);
    check("l_d_rdata", dr, 32'hCAFEF00D);
    check("l_i_ack", ia, 0);

    // Spurious mem_ack in IDLE
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h55;
    #1;
    check("sp_i_ack", bus.i_ack, 0);
    check("sp_d_ack", bus.d_ack, 0);
    check("sp_d_rdata", bus.d_rdata, 0);
    tick();
    check("sp_idle", bus.mem_req, 0);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;

    // Starvation: d_req held continuously alongside a waiting fetch
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h400;
    bus.d_wdata = 32'h1;
    bus.i_req   = 1'b1;
    bus.i_addr  = 32'h108;
    fetch_seq   = '0;
    for (int k = 0; k < 8; k++) begin
      wait_busy("st_busy");
      respond(32'h20 + XLEN'(k), 1'b1, ia, da, ir, dr);
      fetch_seq[k] = ia;
      check("st_one_ack", ia ^ da, 1);
    end
`ifdef MEM_ARB_STARVE_EN
    exp_seq = 8'b0001_0000;
`else
    exp_seq = 8'b0000_0000;
`endif
    check("st_grant_seq", fetch_seq, exp_seq);
    check("st_data_resumes", fetch_seq[5], 0);
    bus.d_req = 1'b0;
    bus.i_req = 1'b0;
    tick();
    tick();

    // Reset in the middle of a store
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h500;
    bus.d_wdata = 32'h12345678;
    tick();
    check("r_busy", bus.mem_req, 1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h77;
    #1;
    check("r_pre_d_ack", bus.d_ack, 1);
    rst_n = 1'b0;
    #1;
    check("r_mem_req", bus.mem_req, 0);
    check("r_mem_we", bus.mem_we, 0);
    check("r_mem_addr", bus.mem_addr, 0);
    check("r_mem_wdata", bus.mem_wdata, 0);
    check("r_d_ack", bus.d_ack, 0);
    check("r_d_rdata", bus.d_rdata, 0);
    bus.d_req     = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("r_post_idle", bus.mem_req, 0);
    bus.mem_ack = 1'b1;
    #1;
    check("r_post_d_ack", bus.d_ack, 0);
    bus.mem_ack = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
